// File: rtl/joy_axis_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : joy_axis_arbiter
// Description : Chooses which host input drives the console analog axes.
//               Sources are the analog stick, PS/2 mouse deltas accumulated
//               into a position, and digital directions ramped toward full
//               scale. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module joy_axis_arbiter #(
    parameter int STEP   = 8,
    parameter int MCLAMP = 10
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [15:0] JOYA,
    input  logic [3:0]  JOYD,
    input  logic [24:0] MOUSE,
    input  logic        HALT,
    input  logic        TICK,
    output logic [7:0]  AX,
    output logic [7:0]  AY,
    output logic [1:0]  SRC,
    output logic [1:0]  MBTN
);

    typedef enum logic [1:0] {
        ST_ANALOG  = 2'd0,
        ST_MOUSE   = 2'd1,
        ST_DIGITAL = 2'd2
    } t_state;

    localparam logic signed [7:0] c_mclamp   = 8'(MCLAMP);
    localparam logic signed [9:0] c_step     = 10'(STEP);
    localparam logic signed [7:0] c_pos_full = 8'sh7F;
    localparam logic signed [7:0] c_neg_full = 8'sh81;

    t_state            r_state;
    t_state            w_state_nx;
    logic signed [7:0] r_accx;
    logic signed [7:0] r_accy;
    logic signed [7:0] w_accx_nx;
    logic signed [7:0] w_accy_nx;
    logic [7:0]        r_ax;
    logic [7:0]        r_ay;
    logic [7:0]        w_ax_nx;
    logic [7:0]        w_ay_nx;
    logic [1:0]        r_mbtn;
    logic [1:0]        w_mbtn_nx;
    logic              r_tog;
    logic              r_armed;
    logic [3:0]        r_joyd_prev;

    logic              w_anz;
    logic              w_pk;
    logic              w_rise;
    logic              w_acc_zero;
    logic signed [7:0] w_dx;
    logic signed [7:0] w_dy;
    logic signed [7:0] w_tgtx;
    logic signed [7:0] w_tgty;
    logic              w_unused_mouse;

    // Clamp a packet delta to +/-MCLAMP, add it to the accumulator in 9 bits
    // and saturate back to the 8-bit signed range.
    function automatic logic signed [7:0] f_mouse_add(
        input logic signed [7:0] acc,
        input logic signed [7:0] delta
    );
        logic signed [7:0] w_d;
        logic signed [8:0] w_sum;
        if (delta > c_mclamp) begin
            w_d = c_mclamp;
        end else if (delta < -c_mclamp) begin
            w_d = -c_mclamp;
        end else begin
            w_d = delta;
        end
        w_sum = {acc[7], acc} + {w_d[7], w_d};
        if (w_sum > 9'sd127) begin
            return 8'sh7F;
        end else if (w_sum < -9'sd128) begin
            return 8'sh80;
        end
        return w_sum[7:0];
    endfunction

    // Move the accumulator toward the target by at most STEP, landing exactly
    // on the target when it is within one step.
    function automatic logic signed [7:0] f_ramp(
        input logic signed [7:0] acc,
        input logic signed [7:0] tgt
    );
        logic signed [9:0] w_diff;
        w_diff = $signed({{2{tgt[7]}}, tgt}) - $signed({{2{acc[7]}}, acc});
        if (w_diff > c_step) begin
            return acc + c_step[7:0];
        end else if (w_diff < -c_step) begin
            return acc - c_step[7:0];
        end
        return tgt;
    endfunction

    assign w_anz      = (JOYA != 16'd0);
    // The toggle copy is refreshed during HALT, so a toggle seen then is consumed.
    assign w_pk       = r_armed && !HALT && (MOUSE[24] != r_tog);
    assign w_rise     = (r_joyd_prev == 4'd0) && (JOYD != 4'd0);
    assign w_acc_zero = (r_accx == 8'sd0) && (r_accy == 8'sd0);
    assign w_dx       = {MOUSE[4], MOUSE[15:9]};
    assign w_dy       = {MOUSE[5], MOUSE[23:17]};
    assign w_tgtx     = (JOYD[0] && !JOYD[1]) ? c_pos_full :
                        (JOYD[1] && !JOYD[0]) ? c_neg_full : 8'sd0;
    assign w_tgty     = (JOYD[2] && !JOYD[3]) ? c_pos_full :
                        (JOYD[3] && !JOYD[2]) ? c_neg_full : 8'sd0;
    assign w_unused_mouse = ^{MOUSE[3:2], MOUSE[7:6], MOUSE[8], MOUSE[16]};

    // Next state, accumulators and the values the output registers will load.
    always_comb begin
        w_state_nx = r_state;
        w_accx_nx  = r_accx;
        w_accy_nx  = r_accy;
        w_ax_nx    = 8'd0;
        w_ay_nx    = 8'd0;
        w_mbtn_nx  = 2'd0;

        if (HALT || w_anz) begin
            w_state_nx = ST_ANALOG;
            w_accx_nx  = 8'sd0;
            w_accy_nx  = 8'sd0;
        end else begin
            case (r_state)
                ST_ANALOG: begin
                    w_accx_nx = 8'sd0;
                    w_accy_nx = 8'sd0;
                    if (w_pk) begin
                        w_state_nx = ST_MOUSE;
                        w_accx_nx  = f_mouse_add(8'sd0, w_dx);
                        w_accy_nx  = f_mouse_add(8'sd0, w_dy);
                    end else if (JOYD != 4'd0) begin
                        w_state_nx = ST_DIGITAL;
                    end
                end
                ST_MOUSE: begin
                    if (w_pk) begin
                        w_accx_nx = f_mouse_add(r_accx, w_dx);
                        w_accy_nx = f_mouse_add(r_accy, w_dy);
                    end else if (w_rise) begin
                        w_state_nx = ST_DIGITAL;
                        w_accx_nx  = 8'sd0;
                        w_accy_nx  = 8'sd0;
                    end
                end
                ST_DIGITAL: begin
                    // A packet wins over a coincident ramp tick.
                    if (w_pk) begin
                        w_state_nx = ST_MOUSE;
                        w_accx_nx  = f_mouse_add(8'sd0, w_dx);
                        w_accy_nx  = f_mouse_add(8'sd0, w_dy);
                    end else if ((JOYD == 4'd0) && w_acc_zero) begin
                        w_state_nx = ST_ANALOG;
                    end else if (TICK) begin
                        w_accx_nx = f_ramp(r_accx, w_tgtx);
                        w_accy_nx = f_ramp(r_accy, w_tgty);
                    end
                end
                default: begin
                    w_state_nx = ST_ANALOG;
                    w_accx_nx  = 8'sd0;
                    w_accy_nx  = 8'sd0;
                end
            endcase
        end

        if (w_state_nx == ST_ANALOG) begin
            w_ax_nx = JOYA[7:0];
            w_ay_nx = JOYA[15:8];
        end else begin
            w_ax_nx = w_accx_nx;
            w_ay_nx = w_accy_nx;
        end
        if (w_state_nx == ST_MOUSE) begin
            w_mbtn_nx = MOUSE[1:0];
        end
    end

    // State, accumulators, outputs and toggle tracking registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= ST_ANALOG;
            r_accx      <= 8'sd0;
            r_accy      <= 8'sd0;
            r_ax        <= 8'd0;
            r_ay        <= 8'd0;
            r_mbtn      <= 2'd0;
            r_tog       <= 1'b0;
            r_armed     <= 1'b0;
            r_joyd_prev <= 4'd0;
        end else begin
            r_state     <= w_state_nx;
            r_accx      <= w_accx_nx;
            r_accy      <= w_accy_nx;
            r_ax        <= w_ax_nx;
            r_ay        <= w_ay_nx;
            r_mbtn      <= w_mbtn_nx;
            r_tog       <= MOUSE[24];
            r_armed     <= 1'b1;
            r_joyd_prev <= JOYD;
        end
    end

    assign AX   = r_ax;
    assign AY   = r_ay;
    assign SRC  = r_state;
    assign MBTN = r_mbtn;

endmodule
`default_nettype wire

// File: tb/tb_joy_axis_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_joy_axis_arbiter
// Description : Scoreboard bench for joy_axis_arbiter. A behavioural model
//               predicts outputs for each clock; a monitor compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_joy_axis_arbiter;

    localparam int P_STEP   = 8;
    localparam int P_MCLAMP = 10;

    logic        CLK;
    logic        RESET_N;
    logic [15:0] JOYA;
    logic [3:0]  JOYD;
    logic [24:0] MOUSE;
    logic        HALT;
    logic        TICK;
    logic [7:0]  AX;
    logic [7:0]  AY;
    logic [1:0]  SRC;
    logic [1:0]  MBTN;

    int total;
    int bad;
    int cyc_no;

    logic [19:0] sb_q[$];
    logic [19:0] sb_exp;

    // Model state: mode 0 analog, 1 mouse, 2 digital.
    int         m_mode;
    int         m_accx;
    int         m_accy;
    logic       m_tog;
    logic       m_armed;
    logic [3:0] m_prevd;

    joy_axis_arbiter #(
        .STEP   (P_STEP),
        .MCLAMP (P_MCLAMP)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .JOYA    (JOYA),
        .JOYD    (JOYD),
        .MOUSE   (MOUSE),
        .HALT    (HALT),
        .TICK    (TICK),
        .AX      (AX),
        .AY      (AY),
        .SRC     (SRC),
        .MBTN    (MBTN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int s8(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    function automatic int clampsat(input int acc, input int d);
        int dc;
        int s;
        dc = (d > P_MCLAMP) ? P_MCLAMP : ((d < -P_MCLAMP) ? -P_MCLAMP : d);
        s  = acc + dc;
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
        return s;
    endfunction

    function automatic int ramp(input int acc, input int tgt);
        int d;
        d = tgt - acc;
        if (d > P_STEP)  return acc + P_STEP;
        if (d < -P_STEP) return acc - P_STEP;
        return tgt;
    endfunction

    function automatic int target(input logic plus, input logic minus);
        if (plus && !minus) return 127;
        if (minus && !plus) return -127;
        return 0;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Predict the outputs after the coming rising edge from the current inputs.
    task automatic model_step();
        logic       pk;
        int         dx;
        int         dy;
        logic [7:0] ex;
        logic [7:0] ey;
        logic [1:0] eb;
        if (!RESET_N) begin
            m_mode  = 0;
            m_accx  = 0;
            m_accy  = 0;
            m_tog   = 1'b0;
            m_armed = 1'b0;
            m_prevd = 4'd0;
            sb_q.push_back(20'd0);
            return;
        end
        pk = m_armed && !HALT && (MOUSE[24] != m_tog);
        dx = s8({MOUSE[4], MOUSE[15:9]});
        dy = s8({MOUSE[5], MOUSE[23:17]});
        if (HALT || (JOYA != 16'd0)) begin
            m_mode = 0; m_accx = 0; m_accy = 0;
        end else if (m_mode == 0) begin
            if (pk) begin
                m_mode = 1; m_accx = clampsat(0, dx); m_accy = clampsat(0, dy);
            end else if (JOYD != 4'd0) begin
                m_mode = 2; m_accx = 0; m_accy = 0;
            end
        end else if (m_mode == 1) begin
            if (pk) begin
                m_accx = clampsat(m_accx, dx); m_accy = clampsat(m_accy, dy);
            end else if (m_prevd == 4'd0 && JOYD != 4'd0) begin
                m_mode = 2; m_accx = 0; m_accy = 0;
            end
        end else begin
            if (pk) begin
                m_mode = 1; m_accx = clampsat(0, dx); m_accy = clampsat(0, dy);
            end else if (JOYD == 4'd0 && m_accx == 0 && m_accy == 0) begin
                m_mode = 0;
            end else if (TICK) begin
                m_accx = ramp(m_accx, target(JOYD[0], JOYD[1]));
                m_accy = ramp(m_accy, target(JOYD[2], JOYD[3]));
            end
        end
        m_tog   = MOUSE[24];
        m_armed = 1'b1;
        m_prevd = JOYD;
        if (m_mode == 0) begin
            ex = JOYA[7:0]; ey = JOYA[15:8];
        end else begin
            ex = m_accx[7:0]; ey = m_accy[7:0];
        end
        eb = (m_mode == 1) ? MOUSE[1:0] : 2'd0;
        sb_q.push_back({ex, ey, m_mode[1:0], eb});
    endtask

    // One clock: inputs already set by the caller; returns just after the
    // monitor has consumed the prediction.
    task automatic step();
        @(negedge CLK);
        model_step();
        @(posedge CLK);
        #2;
    endtask

    // New packet: flip the strobe and fill unused bits with noise.
    task automatic set_pkt(input int dx, input int dy, input logic [1:0] btn);
        logic [24:0] m;
        logic [7:0]  x8;
        logic [7:0]  y8;
        x8 = dx[7:0];
        y8 = dy[7:0];
        m = 25'($urandom);
        m[24]    = ~MOUSE[24];
        m[23:17] = y8[6:0];
        m[15:9]  = x8[6:0];
        m[5]     = y8[7];
        m[4]     = x8[7];
        m[1:0]   = btn;
        MOUSE = m;
    endtask

    // Monitor: compare every presented output against the oldest prediction.
    initial begin
        cyc_no = 0;
        forever begin
            @(posedge CLK);
            #1;
            cyc_no++;
            if (sb_q.size() > 0) begin
                sb_exp = sb_q.pop_front();
                total++;
                if ({AX, AY, SRC, MBTN} !== sb_exp) begin
                    bad++;
                    $display("FAIL scoreboard cycle %0d: got AX=%02h AY=%02h SRC=%0d MBTN=%0d required AX=%02h AY=%02h SRC=%0d MBTN=%0d",
                             cyc_no, AX, AY, SRC, MBTN,
                             sb_exp[19:12], sb_exp[11:4], sb_exp[3:2], sb_exp[1:0]);
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    initial begin
        total   = 0;
        bad     = 0;
        RESET_N = 1'b0;
        JOYA    = 16'd0;
        JOYD    = 4'd0;
        MOUSE   = 25'd0;
        HALT    = 1'b0;
        TICK    = 1'b0;

        // Reset held, strobe high
        MOUSE = 25'h1000000;
        repeat (3) step();
        chk("reset_ax", AX, 0);
        chk("reset_ay", AY, 0);
        chk("reset_src", SRC, 0);
        chk("reset_mbtn", MBTN, 0);

        // Release with strobe still high: no mouse entry
        RESET_N = 1'b1;
        repeat (3) step();
        chk("release_src", SRC, 0);
        chk("release_ax", AX, 0);
        chk("release_ay", AY, 0);

        // First packet X=+40, Y=-6 -> clamp to +10, -6
        set_pkt(40, -6, 2'b01);
        step();
        chk("pkt1_src", SRC, 1);
        chk("pkt1_ax", s8(AX), 10);
        chk("pkt1_ay", s8(AY), -6);
        chk("pkt1_mbtn", MBTN, 1);
        for (int i = 0; i < 12; i++) begin
            set_pkt(40, 0, 2'b01);
            step();
        end
        chk("pkt_sat_ax", s8(AX), 127);

        // Analog override from mouse; same-cycle packet ignored
        JOYA = 16'h0020;
        set_pkt(-50, 30, 2'b10);
        step();
        chk("anz_src", SRC, 0);
        chk("anz_ax", AX, 32);
        chk("anz_ay", AY, 0);
        JOYA = 16'h0000;
        step();
        chk("anz_after_src", SRC, 0);

        // Right ramp, tick every 4 cycles
        JOYD = 4'b0001;
        for (int i = 0; i < 64; i++) begin
            TICK = ((i % 4) == 3);
            step();
        end
        chk("ramp_up_ax", s8(AX), 127);
        chk("ramp_up_src", SRC, 2);
        JOYD = 4'b0000;
        for (int i = 0; i < 64; i++) begin
            TICK = ((i % 4) == 3);
            step();
        end
        chk("ramp_down_ax", AX, 0);
        chk("ramp_down_src", SRC, 2);
        TICK = 1'b0;
        step();
        chk("ramp_exit_src", SRC, 0);

        // Opposing left+right, then add up
        JOYD = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            TICK = ((i % 4) == 3);
            step();
        end
        chk("opp_src", SRC, 2);
        chk("opp_ax", AX, 0);
        JOYD = 4'b1011;
        for (int i = 0; i < 64; i++) begin
            TICK = ((i % 4) == 3);
            step();
        end
        chk("up_ay", s8(AY), -127);

        // HALT in digital with a pending toggle
        TICK = 1'b0;
        HALT = 1'b1;
        JOYD = 4'b0000;
        set_pkt(5, 5, 2'b11);
        step();
        chk("halt_src", SRC, 0);
        chk("halt_ax", AX, 0);
        chk("halt_ay", AY, 0);
        step();
        HALT = 1'b0;
        repeat (3) step();
        chk("post_halt_src", SRC, 0);

        // Packet coinciding with tick in digital takes mouse path
        JOYD = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            TICK = ((i % 2) == 1);
            step();
        end
        set_pkt(3, -2, 2'b00);
        TICK = 1'b1;
        step();
        chk("pktick_src", SRC, 1);
        chk("pktick_ax", s8(AX), 3);
        TICK = 1'b0;
        step();
        JOYD = 4'b0000;
        step();
        JOYD = 4'b0100;
        step();
        chk("rise_src", SRC, 2);

        // Asynchronous reset mid-packet
        JOYD = 4'b0000;
        repeat (2) step();
        set_pkt(20, 20, 2'b11);
        step();
        RESET_N = 1'b0;
        #1;
        chk("areset_ax", AX, 0);
        chk("areset_ay", AY, 0);
        chk("areset_src", SRC, 0);
        chk("areset_mbtn", MBTN, 0);
        repeat (2) step();
        RESET_N = 1'b1;
        step();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            RESET_N = ($urandom_range(0, 299) != 0);
            HALT    = ($urandom_range(0, 39) == 0);
            TICK    = ($urandom_range(0, 2) == 0);
            JOYA    = ($urandom_range(0, 24) == 0) ? 16'($urandom) : 16'h0000;
            if ($urandom_range(0, 9) == 0) begin
                JOYD = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            end
            if ($urandom_range(0, 4) == 0) begin
                set_pkt(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 2'($urandom));
            end
            step();
        end

        chk("queue_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
